sysid_boot_checker: RTL and testbench

SYSID_BOOT_CHECKER -- requirements
Module: sysid_boot_checker

---
 rtl/sysid_chk_pkg.sv | 21 ++
 rtl/sysid_chk_timer.sv | 29 ++
 rtl/sysid_boot_checker.sv | 170 +++++++++++++++++
 tb/tb_sysid_boot_checker.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_chk_pkg.sv
// Shared types for the sysid boot checker.
//   state_t     : checker FSM states
//   fail_code_t : reported failure cause (00 none, 01 ID, 10 TS, 11 timeout)
//   ADDR_ID/TS  : word select on the sysid control slave
package sysid_chk_pkg;

  typedef enum logic [2:0] {
    IDLE, READ_ID, READ_TS, CHECK, PASS, FAIL
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ID      = 2'b01,
    FC_TS      = 2'b10,
    FC_TIMEOUT = 2'b11
  } fail_code_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_chk_timer.sv
// Waitrequest timeout counter for one Avalon read.
//   clock, reset_n : system clock, synchronous active-low reset
//   clear          : restart the count (read not stalled)
//   count_en       : read is stalled this cycle
//   expired        : this stalled cycle is the LIMIT-th consecutive one
module sysid_chk_timer #(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt;

  // Count only reaches LIMIT-1; the expiring cycle wraps it back to zero.
  assign expired = count_en && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (!reset_n)               cnt <= '0;
    else if (clear || expired)  cnt <= '0;
    else if (count_en)          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sysid checker: reads the system ID (and optionally the build
// timestamp) from a sysid slave over Avalon-MM, compares against expected
// values, retries on failure and reports pass/fail.
//
// Optional feature macro: SYSID_CHECK_TS_EN
//   defined   : read word 1 (timestamp) and compare it after the ID
//   undefined : ID only; captured_ts stays 0 and fail_code 10 never occurs
//
// Ports
//   clock, reset_n       : system clock, synchronous active-low reset
//   start                : one-cycle re-check request (honoured in PASS/FAIL)
//   avm_address/avm_read : Avalon-MM master request (word select, strobe)
//   avm_readdata         : slave read data
//   avm_waitrequest      : slave stall
//   busy                 : check in progress
//   id_ok / id_fail      : final verdict
//   fail_code            : cause of the final failure
//   captured_id/_ts      : last words read from the slave
module sysid_boot_checker
  import sysid_chk_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1490972564,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          MAX_RETRIES    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        id_ok,
  output logic        id_fail,
  output logic [1:0]  fail_code,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  state_t     state, state_nxt;
  fail_code_t fail_code_q, cause;
  logic [RW-1:0] retry_cnt;
  logic restart;      // IDLE was entered from a retry, not from reset
  logic cap_id, cap_ts, fail_ev, start_ev, stall, tmr_expired, can_retry;

  assign stall     = ((state == READ_ID) || (state == READ_TS)) && avm_waitrequest;
  assign can_retry = retry_cnt < RW'(MAX_RETRIES);
  assign fail_code = fail_code_q;

  sysid_chk_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (!stall),
    .count_en (stall),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    avm_read    = 1'b0;
    avm_address = ADDR_ID;
    busy        = 1'b0;
    id_ok       = 1'b0;
    id_fail     = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    fail_ev     = 1'b0;
    start_ev    = 1'b0;
    cause       = FC_NONE;
    unique case (state)
      IDLE: begin
        busy      = restart;
        state_nxt = READ_ID;
      end
      READ_ID: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = ADDR_ID;
        if (!avm_waitrequest) begin
          cap_id    = 1'b1;
          state_nxt = TS_EN ? READ_TS : CHECK;
        end else if (tmr_expired) begin
          fail_ev = 1'b1;
          cause   = FC_TIMEOUT;
        end
      end
      READ_TS: begin
        busy        = 1'b1;
        avm_read    = 1'b1;
        avm_address = ADDR_TS;
        if (!avm_waitrequest) begin
          cap_ts    = 1'b1;
          state_nxt = CHECK;
        end else if (tmr_expired) begin
          fail_ev = 1'b1;
          cause   = FC_TIMEOUT;
        end
      end
      CHECK: begin
        busy = 1'b1;
        // ID mismatch outranks a timestamp mismatch.
        if (captured_id != EXPECTED_ID) begin
          fail_ev = 1'b1;
          cause   = FC_ID;
        end else if (TS_EN && (captured_ts != EXPECTED_TS)) begin
          fail_ev = 1'b1;
          cause   = FC_TS;
        end else begin
          state_nxt = PASS;
        end
      end
      PASS: begin
        id_ok = 1'b1;
        if (start) begin
          start_ev  = 1'b1;
          state_nxt = READ_ID;
        end
      end
      FAIL: begin
        id_fail = 1'b1;
        if (start) begin
          start_ev  = 1'b1;
          state_nxt = READ_ID;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A failure either burns a retry via one idle cycle or ends the check.
    if (fail_ev) state_nxt = can_retry ? IDLE : FAIL;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      captured_id <= '0;
      captured_ts <= '0;
      retry_cnt   <= '0;
      restart     <= 1'b0;
      fail_code_q <= FC_NONE;
    end else begin
      if (cap_id) captured_id <= avm_readdata;
`ifdef SYSID_CHECK_TS_EN
      if (cap_ts) captured_ts <= avm_readdata;
`endif
      restart <= fail_ev && can_retry;
      if (start_ev) begin
        retry_cnt   <= '0;
        fail_code_q <= FC_NONE;
      end else if (fail_ev) begin
        if (can_retry) retry_cnt   <= retry_cnt + RW'(1);
        else           fail_code_q <= cause;
      end
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker. A behavioural slave serves a
// queue of planned responses; a reference model turns each planned check
// into an expected verdict/latency pushed on a queue that the monitor pops
// whenever id_ok or id_fail rises. Works with or without SYSID_CHECK_TS_EN.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1490972564;
  localparam int TO   = 16;
  localparam int MAXR = 2;
`ifdef SYSID_CHECK_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic        clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic        avm_address, avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        busy, id_ok, id_fail;
  logic [1:0]  fail_code;
  logic [31:0] captured_id, captured_ts;

  sysid_boot_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MAXR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .id_ok(id_ok), .id_fail(id_fail), .fail_code(fail_code),
    .captured_id(captured_id), .captured_ts(captured_ts)
  );

  always #5 clock = ~clock;

  int vectors = 0, miscompares = 0;
  int cyc = 0, origin = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave ----------------
  typedef struct { logic addr; int waits; logic [31:0] data; } rsp_t;
  rsp_t slv_q[$];
  rsp_t cur;
  bit   cur_v = 1'b0;

  always @(negedge clock) begin
    if (!avm_read) begin
      cur_v = 1'b0;
      avm_waitrequest = 1'b0;
    end else begin
      if (!cur_v) begin
        vectors++;
        if (slv_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_read: got read of word %0d expected no read (cycle %0d)", avm_address, cyc);
          cur = '{avm_address, 0, 32'hBAD0_BAD0};
        end else begin
          cur = slv_q.pop_front();
          if (avm_address !== cur.addr) begin
            miscompares++;
            $display("FAIL read_addr: got %0d expected %0d (cycle %0d)", avm_address, cur.addr, cyc);
          end
        end
        cur_v = 1'b1;
      end
      if (cur.waits > 0) begin
        avm_waitrequest = 1'b1;
        cur.waits--;
      end else begin
        avm_waitrequest = 1'b0;
        avm_readdata    = cur.data;
        cur_v           = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { bit ok; logic [1:0] code; logic [31:0] id; logic [31:0] ts; int lat; } exp_t;
  exp_t exp_q[$];
  int          a_idw[MAXR+1], a_tsw[MAXR+1];
  logic [31:0] a_idd[MAXR+1], a_tsd[MAXR+1];
  logic [31:0] m_id = '0, m_ts = '0;   // last words the slave handed over

  // Latency counts from the cycle before the first READ_ID (offset 1):
  // a good read takes waits+1 cycles, a timed-out read TO cycles, the
  // compare 1 cycle, and each retry one idle cycle.
  task automatic plan();
    exp_t e;
    int   cause;
    e = '{1'b0, 2'd0, '0, '0, 1};
    for (int a = 0; a <= MAXR; a++) begin
      cause = 0;
      slv_q.push_back('{1'b0, a_idw[a], a_idd[a]});
      if (a_idw[a] >= TO) begin
        e.lat += TO; cause = 3;
      end else begin
        e.lat += a_idw[a] + 1;
        m_id = a_idd[a];
        if (TS_EN) begin
          slv_q.push_back('{1'b1, a_tsw[a], a_tsd[a]});
          if (a_tsw[a] >= TO) begin
            e.lat += TO; cause = 3;
          end else begin
            e.lat += a_tsw[a] + 1;
            m_ts = a_tsd[a];
          end
        end
        if (cause == 0) begin
          e.lat += 1;
          if (m_id != EXP_ID)                 cause = 1;
          else if (TS_EN && m_ts != EXP_TS)   cause = 2;
        end
      end
      if (cause == 0) begin
        e.ok = 1'b1;
        break;
      end
      if (a == MAXR) e.code = cause[1:0];
      else           e.lat += 1;
    end
    e.id = m_id;
    e.ts = m_ts;
    exp_q.push_back(e);
  endtask

  task automatic fill(input int idw, input logic [31:0] idd, input int tsw, input logic [31:0] tsd);
    for (int a = 0; a <= MAXR; a++) begin
      a_idw[a] = idw; a_idd[a] = idd; a_tsw[a] = tsw; a_tsd[a] = tsd;
    end
  endtask

  // ---------------- monitor ----------------
  exp_t e_mon;
  bit   done_prev = 1'b0, prev_rd = 1'b0;
  logic prev_addr = 1'b0;
  int   wait_run = 0;

  always @(posedge clock) begin
    #1;
    cyc++;
    chk("ok_fail_exclusive", {31'd0, id_ok & id_fail}, 32'd0);
    if (reset_n && prev_rd && avm_waitrequest) begin
      wait_run++;
      if (wait_run < TO) begin
        chk("read_held", avm_read, 1);
        chk("addr_held", avm_address, prev_addr);
      end else begin
        chk("timeout_abort", avm_read, 0);
        wait_run = 0;
      end
    end else begin
      wait_run = 0;
    end
    if ((id_ok | id_fail) && !done_prev) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: got ok=%0d fail=%0d expected no verdict", id_ok, id_fail);
      end else begin
        e_mon = exp_q.pop_front();
        chk("verdict_ok",   id_ok,       e_mon.ok);
        chk("verdict_fail", id_fail,     !e_mon.ok);
        chk("fail_code",    fail_code,   e_mon.code);
        chk("captured_id",  captured_id, e_mon.id);
        chk("captured_ts",  captured_ts, e_mon.ts);
        chk("latency",      cyc - origin, e_mon.lat);
      end
    end
    if (id_ok | id_fail) chk("busy_when_done", busy, 0);
    done_prev = id_ok | id_fail;
    prev_rd   = avm_read;
    prev_addr = avm_address;
  end

  // ---------------- driver ----------------
  task automatic boot();
    @(negedge clock);
    reset_n = 1'b1;
    origin  = cyc;
  endtask

  task automatic relaunch();
    @(negedge clock);
    start  = 1'b1;
    origin = cyc;
    @(posedge clock); #1;
    chk("busy_after_start", busy, 1);
    chk("ok_cleared",       id_ok, 0);
    chk("fail_cleared",     id_fail, 0);
    chk("code_cleared",     fail_code, 0);
    @(negedge clock);
    start = 1'b0;
  endtask

  // start while busy must be ignored
  task automatic pulse_busy();
    @(negedge clock);
    chk("busy_at_pulse", busy, 1);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL done_timeout: got %0d verdicts pending expected 0", exp_q.size());
      exp_q.delete();
    end
    chk("reads_consumed", slv_q.size(), 0);
    @(negedge clock);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read"}, avm_read, 0);
    chk({tag, "_addr"}, avm_address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ok"},   id_ok, 0);
    chk({tag, "_fail"}, id_fail, 0);
    chk({tag, "_code"}, fail_code, 0);
    chk({tag, "_id"},   captured_id, 0);
    chk({tag, "_ts"},   captured_ts, 0);
  endtask

  initial begin
    int n;
    start = 1'b1;                      // ignored while in reset
    repeat (3) @(negedge clock);
    start = 1'b0;
    chk_zero("reset");

    // zero-wait slave, good words; start during READ_ID ignored
    fill(0, EXP_ID, 0, EXP_TS);
    plan();
    boot();
    @(negedge clock);
    chk("in_read_id", {avm_read, avm_address}, 2'b10);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();

    // wrong ID every attempt
    fill(0, 32'h5, 0, EXP_TS);
    plan(); relaunch(); wait_done();

    // slave stalls forever
    fill(40, EXP_ID, 0, EXP_TS);
    plan(); relaunch(); wait_done();

    // 5-cycle stall on the last read, correct data
    fill(0, EXP_ID, 5, EXP_TS);
    if (!TS_EN) fill(5, EXP_ID, 0, EXP_TS);
    plan(); relaunch(); pulse_busy(); wait_done();

    // timeout boundary: TO-1 stalls succeed, TO stalls abort
    fill(TO - 1, EXP_ID, TO - 1, EXP_TS);
    plan(); relaunch(); wait_done();
    fill(0, EXP_ID, 0, EXP_TS);
    a_idw[0] = TO; a_tsw[1] = TO;
    plan(); relaunch(); wait_done();

    // timestamp wrong every attempt
    fill(0, EXP_ID, 0, 32'h1234_5678);
    plan(); relaunch(); wait_done();

    // ID + TS both wrong on the last attempt: ID wins
    fill(0, EXP_ID, 0, 32'h1);
    a_idd[MAXR] = 32'h7;
    a_idw[1] = TO + 2;
    plan(); relaunch(); wait_done();

    // reset in the middle of a stalled read
    slv_q.push_back('{1'b0, TS_EN ? 0 : 10, EXP_ID});
    if (TS_EN) slv_q.push_back('{1'b1, 10, EXP_TS});
    relaunch();
    n = 0;
    while (!(avm_read && avm_address == TS_EN) && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    start   = 1'b1;
    @(posedge clock); #1;
    chk_zero("midreset");
    @(negedge clock);
    @(negedge clock);
    start = 1'b0;
    slv_q.delete();
    m_id = '0; m_ts = '0;
    fill(0, EXP_ID, 0, EXP_TS);
    plan(); boot(); wait_done();

    // randomized checks
    for (int s = 0; s < 25; s++) begin
      for (int a = 0; a <= MAXR; a++) begin
        n = $urandom_range(0, 9);
        a_idw[a] = (n == 0) ? TO + $urandom_range(0, 3) : (n == 1) ? TO - 1 : $urandom_range(0, 4);
        a_idd[a] = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
        n = $urandom_range(0, 9);
        a_tsw[a] = (n == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
        a_tsd[a] = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
      end
      plan();
      relaunch();
      if ($urandom_range(0, 1) == 1) pulse_busy();
      wait_done();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run expected finish before 500000 ns");
    $fatal(1, "watchdog");
  end

endmodule
